// File: rtl/pcc_class_scheduler.sv
// pcc_class_scheduler: shares one external popcount-compare (pcc) core across
// NUM_CLASSES binarized class neurons. A feature word is latched, then each class
// gets one cycle in which its XOR-weighted operands are presented to the pcc and
// the decision bit is captured. The result vector and the lowest winning class are
// held until the downstream consumer accepts them.
module pcc_class_scheduler #(
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned POS_W       = 2,
  parameter int unsigned NEG_W       = 6,
  parameter int unsigned CW          = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  // Feature word input
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [POS_W-1:0]       in_pos,
  input  logic [NEG_W-1:0]       in_neg,
  // Weight configuration
  input  logic                   cfg_we,
  input  logic [CW-1:0]          cfg_addr,
  input  logic [POS_W+NEG_W-1:0] cfg_data,
  output logic                   cfg_err,
  // Shared pcc core
  output logic [POS_W-1:0]       pcc_pos,
  output logic [NEG_W-1:0]       pcc_neg,
  input  logic                   pcc_outval,
  // Result output
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CLASSES-1:0] out_result,
  output logic [CW-1:0]          out_class,
  output logic                   out_none
);

  localparam int unsigned WW = POS_W + NEG_W;
  localparam logic [CW-1:0] LastIdx = CW'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [POS_W-1:0]       x_pos_q;
  logic [NEG_W-1:0]       x_neg_q;
  logic [CW-1:0]          idx_q;
  logic [NUM_CLASSES-1:0] res_q;
  logic [NUM_CLASSES-1:0] res_final;
  logic [CW-1:0]          cls_q, cls_d;
  logic                   none_q, none_d;
  logic                   err_q;

  logic [POS_W-1:0] w_pos_q [NUM_CLASSES];
  logic [NEG_W-1:0] w_neg_q [NUM_CLASSES];

  logic in_fire;
  logic run_last;
  logic addr_ok;
  logic wr_accept;
  logic wr_drop;

  assign in_fire  = in_valid && (state_q == StIdle);
  assign run_last = (state_q == StRun) && (idx_q == LastIdx);

  // Extra bit keeps the compare well-formed when NUM_CLASSES is a power of two.
  assign addr_ok   = ({1'b0, cfg_addr} < (CW + 1)'(NUM_CLASSES));
  assign wr_accept = cfg_we && (state_q == StIdle) && addr_ok;
  assign wr_drop   = cfg_we && !wr_accept;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on handshake, RUN for NUM_CLASSES cycles, DONE until accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_fire) state_d = StRun;
      StRun:  if (run_last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state and datapath registers.
  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StDone);
    out_result = res_q;
    out_class  = cls_q;
    out_none   = none_q;
    cfg_err    = err_q;
    pcc_pos    = '0;
    pcc_neg    = '0;
    if (state_q == StRun) begin
      pcc_pos = x_pos_q ^ w_pos_q[idx_q];
      pcc_neg = x_neg_q ^ w_neg_q[idx_q];
    end
  end

  // Feature latch and class counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos_q <= '0;
      x_neg_q <= '0;
      idx_q   <= '0;
    end else begin
      if (in_fire) begin
        x_pos_q <= in_pos;
        x_neg_q <= in_neg;
        idx_q   <= '0;
      end else if ((state_q == StRun) && !run_last) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // Result vector as it will stand after this cycle's decision is captured.
  always_comb begin
    res_final        = res_q;
    res_final[idx_q] = pcc_outval;
  end

  // Priority encode: lowest set bit wins, scanned high-to-low so the lowest is written last.
  always_comb begin
    cls_d  = '0;
    none_d = 1'b1;
    for (int c = NUM_CLASSES - 1; c >= 0; c--) begin
      if (res_final[c]) begin
        cls_d  = CW'(c);
        none_d = 1'b0;
      end
    end
  end

  // Capture per-class decisions and register the encoded summary on the RUN->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      cls_q  <= '0;
      none_q <= 1'b0;
    end else if (state_q == StRun) begin
      res_q <= res_final;
      if (run_last) begin
        cls_q  <= cls_d;
        none_q <= none_d;
      end
    end
  end

  // Weight store; writes land only in IDLE so RUN never sees a weight change mid-word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        w_pos_q[c] <= '0;
        w_neg_q[c] <= '0;
      end
    end else if (wr_accept) begin
      w_pos_q[cfg_addr] <= cfg_data[WW-1:NEG_W];
      w_neg_q[cfg_addr] <= cfg_data[NEG_W-1:0];
    end
  end

  // Sticky dropped-write flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wr_drop) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcc_class_scheduler.sv
// Directed bench for pcc_class_scheduler with an exact pcc model in the loop.
module tb_pcc_class_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned NW = 6;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pos;
  logic [NW-1:0] in_neg;
  logic          cfg_we;
  logic [CW-1:0] cfg_addr;
  logic [PW+NW-1:0] cfg_data;
  logic          cfg_err;
  logic [PW-1:0] pcc_pos;
  logic [NW-1:0] pcc_neg;
  logic          pcc_outval;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_result;
  logic [CW-1:0] out_class;
  logic          out_none;

  int n_assert = 0;
  int n_fail   = 0;

  // Bench-side copy of the weights, used to predict pcc operands.
  logic [PW-1:0] m_wp [N];
  logic [NW-1:0] m_wn [N];

  pcc_class_scheduler #(
    .NUM_CLASSES(N),
    .POS_W(PW),
    .NEG_W(NW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pos(in_pos),
    .in_neg(in_neg),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_err(cfg_err),
    .pcc_pos(pcc_pos),
    .pcc_neg(pcc_neg),
    .pcc_outval(pcc_outval),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_class(out_class),
    .out_none(out_none)
  );

  always #5 clk = ~clk;

  // Exact pcc: popcount(pos) >= popcount(neg).
  assign pcc_outval = ($countones(pcc_pos) >= $countones(pcc_neg));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [CW-1:0] a, input logic [PW-1:0] wp,
                         input logic [NW-1:0] wn);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = {wp, wn};
    step;
    cfg_we   = 1'b0;
    m_wp[a]  = wp;
    m_wn[a]  = wn;
  endtask

  // Present one word in IDLE and run until out_valid; pulse_k > 0 fires a write in that RUN cycle.
  task automatic run_word(input logic [PW-1:0] p, input logic [NW-1:0] n, input int pulse_k);
    int lat;
    in_valid = 1'b1;
    in_pos   = p;
    in_neg   = n;
    check("in_ready_idle", in_ready, 1);
    step;
    lat      = 1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (lat <= N) begin
        check("run_in_ready", in_ready, 0);
        check("pcc_pos", pcc_pos, p ^ m_wp[lat-1]);
        check("pcc_neg", pcc_neg, n ^ m_wn[lat-1]);
        if (lat == pulse_k) begin
          cfg_we   = 1'b1;
          cfg_addr = '0;
          cfg_data = '0;
        end
      end
      step;
      cfg_we = 1'b0;
      lat++;
    end
    // Handshake cycle counts as cycle 0; DONE is reached N+1 cycles later.
    check("latency", lat, N + 1);
  endtask

  task automatic check_out(input logic [N-1:0] r, input logic [CW-1:0] c, input logic nn);
    check("out_valid", out_valid, 1);
    check("out_result", out_result, r);
    check("out_class", out_class, c);
    check("out_none", out_none, nn);
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("ready_back", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_neg    = '0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    out_ready = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_wp[c] = '0;
      m_wn[c] = '0;
    end
    step;
    step;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_none", out_none, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_pcc_pos", pcc_pos, 0);
    check("rst_pcc_neg", pcc_neg, 0);
    rst = 1'b0;
    step;

    // All-zero weights: every class ties 2 vs 2 and fires
    run_word(2'b11, 6'b000011, 0);
    check_out(4'b1111, 2'd0, 1'b0);
    release_out();

    // Classes 0 and 1 see six negative bits and lose
    write_w(2'd0, 2'b00, 6'b111100);
    write_w(2'd1, 2'b00, 6'b111100);
    check("cfg_err_idle_write", cfg_err, 0);
    run_word(2'b11, 6'b000011, 0);
    check_out(4'b1100, 2'd2, 1'b0);
    release_out();

    // No class fires
    write_w(2'd2, 2'b00, 6'b111100);
    write_w(2'd3, 2'b00, 6'b111100);
    run_word(2'b11, 6'b000011, 0);
    check_out(4'b0000, 2'd0, 1'b1);
    release_out();

    // Write during RUN at idx 2 is dropped and flags cfg_err
    run_word(2'b11, 6'b000011, 3);
    check_out(4'b0000, 2'd0, 1'b1);
    check("cfg_err_set", cfg_err, 1);
    release_out();
    run_word(2'b11, 6'b000011, 0);
    check_out(4'b0000, 2'd0, 1'b1);
    check("cfg_err_sticky", cfg_err, 1);
    release_out();

    // Backpressure: class 3 alone fires, held in DONE while a new word waits
    write_w(2'd3, 2'b00, 6'b000000);
    run_word(2'b11, 6'b000011, 0);
    check_out(4'b1000, 2'd3, 1'b0);
    in_valid = 1'b1;
    in_pos   = 2'b11;
    in_neg   = 6'b111100;
    for (int i = 0; i < 10; i++) begin
      step;
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, 4'b1000);
      check("hold_class", out_class, 2'd3);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check("bp_valid_drop", out_valid, 0);
    check("bp_in_ready", in_ready, 1);
    step;
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    check("bp_pcc_neg0", pcc_neg, 6'b000000);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step;
    check_out(4'b0111, 2'd0, 1'b0);
    release_out();

    // Reset during RUN at idx 1 abandons the word and clears everything
    in_valid = 1'b1;
    in_pos   = 2'b11;
    in_neg   = 6'b000011;
    step;
    in_valid = 1'b0;
    step;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_pcc_pos", pcc_pos, 0);
    step;
    rst = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_wp[c] = '0;
      m_wn[c] = '0;
    end
    check("midrst_cfg_err", cfg_err, 0);
    check("midrst_no_result", out_valid, 0);
    run_word(2'b11, 6'b000011, 0);
    check_out(4'b1111, 2'd0, 1'b0);
    release_out();

    // Weight write on the handshake edge applies to that word
    cfg_we   = 1'b1;
    cfg_addr = 2'd1;
    cfg_data = {2'b00, 6'b111100};
    m_wn[1]  = 6'b111100;
    run_word(2'b11, 6'b000011, 0);
    check_out(4'b1101, 2'd0, 1'b0);
    check("same_edge_cfg_err", cfg_err, 0);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
